// File: rtl/alu_arbiter_if.sv
// Shared ALU types plus the requester/response bundle of the ALU arbiter.
// The master side is the requester pair and response consumer; the slave side is the arbiter.
package alu_arbiter_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL,
        ALU_SRL,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU
    } aluop_t;
endpackage

interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int W = $bits(word_t)
);
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req_portA0;
    logic [W-1:0] req_portB0;
    aluop_t       req_op0;
    logic [W-1:0] req_portA1;
    logic [W-1:0] req_portB1;
    aluop_t       req_op1;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_negative;
    logic         rsp_overflow;
    logic         rsp_zero;
    logic         busy;

    modport master (
        output req_valid, req_portA0, req_portB0, req_op0,
               req_portA1, req_portB1, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result,
               rsp_negative, rsp_overflow, rsp_zero, busy
    );

    modport slave (
        input  req_valid, req_portA0, req_portB0, req_op0,
               req_portA1, req_portB1, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result,
               rsp_negative, rsp_overflow, rsp_zero, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One op in flight: IDLE (grant/accept) -> EXEC (ALU settles) -> RESP (held until consumed).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int W = $bits(word_t)
) (
    input  logic          CLK,
    input  logic          nRST,
    alu_arbiter_if.slave  bus,
    output logic [W-1:0]  alu_portA,
    output logic [W-1:0]  alu_portB,
    output aluop_t        alu_op,
    input  logic [W-1:0]  alu_portOut,
    input  logic          alu_negative,
    input  logic          alu_overflow,
    input  logic          alu_zero
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic         r_prio;
    logic         r_id;
    logic [W-1:0] r_alu_portA;
    logic [W-1:0] r_alu_portB;
    aluop_t       r_alu_op;
    logic [W-1:0] r_rsp_result;
    logic         r_rsp_negative;
    logic         r_rsp_overflow;
    logic         r_rsp_zero;

    logic         w_grant;
    logic         w_accept;
    logic [1:0]   w_req_ready;
    logic         w_rsp_valid;
    logic         w_busy;

    // Winner: a lone requester wins outright; under contention the priority pointer decides.
    // nRST gates accept so no requester sees ready while reset is held.
    assign w_grant  = (bus.req_valid == 2'b11) ? r_prio : bus.req_valid[1];
    assign w_accept = (r_state == S_IDLE) && (|bus.req_valid) && nRST;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: one op in flight, response must be consumed before returning to IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode: ready only for the granted requester in IDLE, valid only in RESP
    always_comb begin
        w_req_ready = 2'b00;
        w_rsp_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy         = 1'b0;
                w_req_ready[0] = w_accept && !w_grant;
                w_req_ready[1] = w_accept && w_grant;
            end
            S_RESP:  w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand/id/priority capture on accept; ALU outputs captured at the end of EXEC
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_prio         <= 1'b0;
            r_id           <= 1'b0;
            r_alu_portA    <= '0;
            r_alu_portB    <= '0;
            r_alu_op       <= aluop_t'(0);
            r_rsp_result   <= '0;
            r_rsp_negative <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_zero     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_portA <= w_grant ? bus.req_portA1 : bus.req_portA0;
                r_alu_portB <= w_grant ? bus.req_portB1 : bus.req_portB0;
                r_alu_op    <= w_grant ? bus.req_op1    : bus.req_op0;
                r_id        <= w_grant;
                r_prio      <= ~w_grant;
            end
            if (r_state == S_EXEC) begin
                r_rsp_result   <= alu_portOut;
                r_rsp_negative <= alu_negative;
                r_rsp_overflow <= alu_overflow;
                r_rsp_zero     <= alu_zero;
            end
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.rsp_valid    = w_rsp_valid;
    assign bus.busy         = w_busy;
    assign bus.rsp_id       = r_id;
    assign bus.rsp_result   = r_rsp_result;
    assign bus.rsp_negative = r_rsp_negative;
    assign bus.rsp_overflow = r_rsp_overflow;
    assign bus.rsp_zero     = r_rsp_zero;

    assign alu_portA = r_alu_portA;
    assign alu_portB = r_alu_portB;
    assign alu_op    = r_alu_op;
endmodule
